spi_frame_loader: RTL
=====================

# spi_frame_loader

Byte-stream frame decoder sitting between the SPI byte receiver and the external write ports of the processor's activation, parameter and instruction memories. It parses a header/address/length preamble, packs payload bytes little-endian into memory-width words, and issues single-cycle write strobes with auto-incrementing addresses. It reports frame completion and protocol errors to the control logic.

## Interface
- WIDTH_ADDR_ACT, 12, activation memory address width
- WIDTH_ACT_MEM, 8, activation word width (1 byte)
- WIDTH_ADDR_PARAM, 15, parameter memory address width
- WIDTH_PARAM_MEM, 128, parameter word width (16 bytes)
- WIDTH_ADDR_INST, 6, instruction memory address width
- WIDTH_INST_MEM, 80, instruction word width (10 bytes)
- ACT_MEM_HEADER / PARAM_MEM_HEADER / INST_MEM_HEADER, 8'b10 / 8'b01 / 8'b11, target select header codes

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_active  in  1  chip select asserted, already synchronised to clk
- rx_byte  in  8  received SPI byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- act_mem_addr / act_mem_data / act_mem_wren  out  12 / 8 / 1  activation write port
- param_mem_addr / param_mem_data / param_mem_wren  out  15 / 128 / 1  parameter write port
- inst_mem_addr / inst_mem_data / inst_mem_wren  out  6 / 80 / 1  instruction write port
- busy  out  1  frame being parsed (state != IDLE)
- frame_done  out  1  one-cycle pulse, all declared words written
- error  out  1  sticky protocol error; cleared on next header byte accepted

## Operation
- Frame format: HDR, ADDR_H, ADDR_L, LEN_H, LEN_L, payload. Address is the start word address, LEN the word count, both 16-bit big-endian; address truncated to target width.
- States: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, DISCARD.
- IDLE: on rx_valid with frame_active, latch header. Known code -> ADDR_H and clear error; unknown -> DISCARD and set error.
- ADDR_H/ADDR_L/LEN_H/LEN_L: each consumes one rx_valid byte. After LEN_L: LEN = 0 -> pulse frame_done and go to DISCARD; else DATA.
- DATA: bytes packed little-endian (byte k -> bits [8k+7:8k]) into a shift buffer; byte counter runs 0..BPW-1 (BPW = 1/16/10 by target). On the last byte of a word: load target data/addr, pulse that target's wren, increment address (wraps modulo 2^width), decrement remaining count. Remaining reaches 0 -> pulse frame_done, go to DISCARD.
- DISCARD: ignore all bytes; any rx_valid in DISCARD after a completed frame sets error (overrun).
- frame_active low in any state -> IDLE next cycle, byte counter and buffer cleared. If it drops in ADDR_H..LEN_L or DATA with words remaining or a partial word held, set error; no partial word is written.
- Only one wren asserted at a time; non-target ports keep wren low and hold their last addr/data.

## Timing
- Reset: state IDLE; all addr, data, wren outputs 0; busy, frame_done, error 0.
- All outputs registered. wren, addr and data for a word are valid together in the cycle after the rx_valid of its final byte, for exactly one cycle of wren; addr/data then hold until the next write.
- frame_done asserts the same cycle as the final wren (or the cycle after LEN_L when LEN = 0).
- rx_valid may arrive on consecutive cycles; throughput one byte per cycle, no stalls, no backpressure.
- rx_valid coincident with frame_active falling: byte ignored, abort rules apply.
- Asynchronous reset mid-frame: immediate return to reset values; no write completes.

## Test plan
- Act frame 02 00 10 00 03 AA BB CC -> act_mem_wren pulses 3 times at addr 0x010/0x011/0x012 with data AA/BB/CC; frame_done with third pulse.
- Param frame 01 00 05 00 01 + bytes 00..0F -> one param_mem_wren, addr 0x0005, data 0x0F0E..0100; no wren before 16th byte.
- Inst frame 03 00 3F 00 02 + 20 bytes -> writes at addr 63 then 0 (wrap), 80-bit little-endian data, frame_done on second.
- Header 0x07 then bytes -> no wren, error=1, busy=1 until frame_active drops; next valid frame header clears error.
- Param frame LEN=1 with frame_active dropped after 9 payload bytes -> no wren, error=1, state IDLE next cycle.
- LEN=0 frame -> frame_done one cycle after LEN_L, no wren; extra byte afterwards -> error=1.

Source files
------------

// File: rtl/spi_frame_loader.sv
// Frame decoder between the SPI byte receiver and the memory write ports.
// Parses HDR/ADDR/LEN, packs payload bytes little-endian, issues one-cycle write strobes.
module spi_frame_loader #(
  parameter int         WIDTH_ADDR_ACT   = 12,
  parameter int         WIDTH_ACT_MEM    = 8,
  parameter int         WIDTH_ADDR_PARAM = 15,
  parameter int         WIDTH_PARAM_MEM  = 128,
  parameter int         WIDTH_ADDR_INST  = 6,
  parameter int         WIDTH_INST_MEM   = 80,
  parameter logic [7:0] ACT_MEM_HEADER   = 8'b10,
  parameter logic [7:0] PARAM_MEM_HEADER = 8'b01,
  parameter logic [7:0] INST_MEM_HEADER  = 8'b11
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_active,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_valid,
  output logic [WIDTH_ADDR_ACT-1:0]   act_mem_addr,
  output logic [WIDTH_ACT_MEM-1:0]    act_mem_data,
  output logic                        act_mem_wren,
  output logic [WIDTH_ADDR_PARAM-1:0] param_mem_addr,
  output logic [WIDTH_PARAM_MEM-1:0]  param_mem_data,
  output logic                        param_mem_wren,
  output logic [WIDTH_ADDR_INST-1:0]  inst_mem_addr,
  output logic [WIDTH_INST_MEM-1:0]   inst_mem_data,
  output logic                        inst_mem_wren,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        error
);

  localparam int BPW_ACT    = WIDTH_ACT_MEM / 8;
  localparam int BPW_PARAM  = WIDTH_PARAM_MEM / 8;
  localparam int BPW_INST   = WIDTH_INST_MEM / 8;
  localparam int MAX_BPW_AP = (BPW_ACT > BPW_PARAM) ? BPW_ACT : BPW_PARAM;
  localparam int MAX_BPW    = (MAX_BPW_AP > BPW_INST) ? MAX_BPW_AP : BPW_INST;
  localparam int CNT_W      = (MAX_BPW > 1) ? $clog2(MAX_BPW) : 1;
  localparam int BUF_W      = MAX_BPW * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_DISCARD
  } state_t;

  typedef enum logic [1:0] {
    TGT_ACT,
    TGT_PARAM,
    TGT_INST
  } target_t;

  state_t           state_reg;
  state_t           state_next;
  target_t          target_reg;
  target_t          target_next;
  logic             hdr_known;
  logic [15:0]      addr_reg;
  logic [7:0]       len_h_reg;
  logic [15:0]      remaining_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [CNT_W-1:0] last_idx;
  logic [BUF_W-1:0] buffer_reg;
  logic [BUF_W-1:0] merged;

  logic abort;
  logic data_byte;
  logic word_write;
  logic done_pulse;
  logic set_error;
  logic clr_error;

  // Header decode; target_next is only meaningful when hdr_known is set.
  always_comb begin
    target_next = TGT_ACT;
    hdr_known   = 1'b1;
    if (rx_byte == ACT_MEM_HEADER) begin
      target_next = TGT_ACT;
    end else if (rx_byte == PARAM_MEM_HEADER) begin
      target_next = TGT_PARAM;
    end else if (rx_byte == INST_MEM_HEADER) begin
      target_next = TGT_INST;
    end else begin
      hdr_known = 1'b0;
    end
  end

  always_comb begin
    case (target_reg)
      TGT_PARAM: last_idx = CNT_W'(BPW_PARAM - 1);
      TGT_INST:  last_idx = CNT_W'(BPW_INST - 1);
      default:   last_idx = CNT_W'(BPW_ACT - 1);
    endcase
  end

  // Buffer view with the incoming byte already placed in its lane, so the final
  // byte of a word can be written out in the same cycle it is accepted.
  for (genvar gi = 0; gi < MAX_BPW; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = (byte_cnt_reg == CNT_W'(gi)) ? rx_byte : buffer_reg[gi*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    abort      = 1'b0;
    data_byte  = 1'b0;
    word_write = 1'b0;
    done_pulse = 1'b0;
    set_error  = 1'b0;
    clr_error  = 1'b0;
    if (!frame_active) begin
      // Chip select loss wins over any coincident byte.
      state_next = S_IDLE;
      abort      = 1'b1;
      if (state_reg != S_IDLE && state_reg != S_DISCARD) begin
        set_error = 1'b1;
      end
    end else if (rx_valid) begin
      case (state_reg)
        S_IDLE: begin
          if (hdr_known) begin
            state_next = S_ADDR_H;
            clr_error  = 1'b1;
          end else begin
            state_next = S_DISCARD;
            set_error  = 1'b1;
          end
        end
        S_ADDR_H: state_next = S_ADDR_L;
        S_ADDR_L: state_next = S_LEN_H;
        S_LEN_H:  state_next = S_LEN_L;
        S_LEN_L: begin
          if ({len_h_reg, rx_byte} == 16'd0) begin
            done_pulse = 1'b1;
            state_next = S_DISCARD;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          data_byte = 1'b1;
          if (byte_cnt_reg == last_idx) begin
            word_write = 1'b1;
            if (remaining_reg == 16'd1) begin
              done_pulse = 1'b1;
              state_next = S_DISCARD;
            end
          end
        end
        S_DISCARD: set_error = 1'b1;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_reg     <= TGT_ACT;
      addr_reg       <= '0;
      len_h_reg      <= '0;
      remaining_reg  <= '0;
      byte_cnt_reg   <= '0;
      buffer_reg     <= '0;
      act_mem_addr   <= '0;
      act_mem_data   <= '0;
      act_mem_wren   <= 1'b0;
      param_mem_addr <= '0;
      param_mem_data <= '0;
      param_mem_wren <= 1'b0;
      inst_mem_addr  <= '0;
      inst_mem_data  <= '0;
      inst_mem_wren  <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      error          <= 1'b0;
    end else begin
      act_mem_wren   <= 1'b0;
      param_mem_wren <= 1'b0;
      inst_mem_wren  <= 1'b0;
      frame_done     <= done_pulse;
      busy           <= (state_next != S_IDLE);
      if (set_error) begin
        error <= 1'b1;
      end else if (clr_error) begin
        error <= 1'b0;
      end

      if (abort) begin
        byte_cnt_reg <= '0;
        buffer_reg   <= '0;
      end else if (rx_valid) begin
        case (state_reg)
          S_IDLE:   target_reg     <= target_next;
          S_ADDR_H: addr_reg[15:8] <= rx_byte;
          S_ADDR_L: addr_reg[7:0]  <= rx_byte;
          S_LEN_H:  len_h_reg      <= rx_byte;
          S_LEN_L:  remaining_reg  <= {len_h_reg, rx_byte};
          default: ;
        endcase
      end

      if (data_byte) begin
        if (word_write) begin
          byte_cnt_reg  <= '0;
          buffer_reg    <= '0;
          // Address counter is 16 bits wide; truncation at the port gives the wrap.
          addr_reg      <= addr_reg + 16'd1;
          remaining_reg <= remaining_reg - 16'd1;
          case (target_reg)
            TGT_PARAM: begin
              param_mem_wren <= 1'b1;
              param_mem_addr <= addr_reg[WIDTH_ADDR_PARAM-1:0];
              param_mem_data <= merged[WIDTH_PARAM_MEM-1:0];
            end
            TGT_INST: begin
              inst_mem_wren <= 1'b1;
              inst_mem_addr <= addr_reg[WIDTH_ADDR_INST-1:0];
              inst_mem_data <= merged[WIDTH_INST_MEM-1:0];
            end
            default: begin
              act_mem_wren <= 1'b1;
              act_mem_addr <= addr_reg[WIDTH_ADDR_ACT-1:0];
              act_mem_data <= merged[WIDTH_ACT_MEM-1:0];
            end
          endcase
        end else begin
          byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
          buffer_reg   <= merged;
        end
      end
    end
  end

endmodule
